// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16-channel output block, each channel static-on or PWM at a shared duty.
// Define PWM_SHADOW_EN to latch the duty at period boundaries instead of using it live.
module pwm_peripheral #(
  parameter int CLK_DIV = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] en_reg_out_7_0,
  input  logic [7:0] en_reg_out_15_8,
  input  logic [7:0] en_reg_pwm_7_0,
  input  logic [7:0] en_reg_pwm_15_8,
  input  logic [7:0] pwm_duty_cycle,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic       pwm_period_start
);
  logic [15:0] prescaler;
  logic [7:0] pwm_cnt, duty_eff;
  logic tick, wrap, pwm_hi;
  logic [15:0] en_out, en_pwm;
  assign tick = prescaler == 16'(CLK_DIV - 1);
  assign wrap = tick && pwm_cnt == 8'd254;
  assign pwm_hi = pwm_cnt < duty_eff;
  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  always_ff @(posedge clk)
    if (rst) begin
      prescaler <= '0;
      pwm_cnt <= '0;
      pwm_period_start <= 1'b0;
      uo_out <= '0;
      uio_out <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 16'd1;
      pwm_cnt <= wrap ? '0 : tick ? pwm_cnt + 8'd1 : pwm_cnt;
      pwm_period_start <= wrap;
      {uio_out, uo_out} <= en_out & (~en_pwm | {16{pwm_hi}});
    end
`ifdef PWM_SHADOW_EN
  // loaded on the last step of a period so the new duty starts with the next period
  always_ff @(posedge clk)
    if (rst) duty_eff <= '0;
    else if (wrap) duty_eff <= pwm_duty_cycle;
`else
  assign duty_eff = pwm_duty_cycle;
`endif
endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: directed checks of pwm_peripheral at CLK_DIV=13 (period 3315 cycles).
module tb_pwm_peripheral;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] en_reg_out_7_0 = '0, en_reg_out_15_8 = '0;
  logic [7:0] en_reg_pwm_7_0 = '0, en_reg_pwm_15_8 = '0;
  logic [7:0] pwm_duty_cycle = '0;
  logic [7:0] uo_out, uio_out;
  logic pwm_period_start;
  int n_chk = 0, n_fail = 0;

  pwm_peripheral #(.CLK_DIV(13)) dut (
    .clk(clk), .rst(rst),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle),
    .uo_out(uo_out), .uio_out(uio_out), .pwm_period_start(pwm_period_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_strobe(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!pwm_period_start && n < 4000);
    check(tag, 32'(pwm_period_start), 1);
  endtask

  // call on a strobe sample; returns on the next strobe sample
  task automatic measure(output int hi, output int len, output int rise, output logic [7:0] uor);
    hi = 0; len = 0; rise = -1; uor = '0;
    do begin
      if (rise < 0 && uo_out[0]) rise = len;
      hi += int'(uo_out[0]);
      uor |= uio_out;
      len++;
      @(negedge clk);
    end while (!pwm_period_start && len < 4000);
  endtask

  initial begin
    int hi, len, rise, n;
    logic [7:0] uor;
    logic o100, o101;
    repeat (3) @(negedge clk);
    check("rst_uo", uo_out, 0);
    check("rst_uio", uio_out, 0);
    check("rst_pps", pwm_period_start, 0);
    rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!pwm_period_start && n < 4000);
    check("first_pps_delay", n, 3315);

    en_reg_out_7_0 = 8'hFF; en_reg_out_15_8 = 8'hA5;
    @(negedge clk);
    check("static_uo", uo_out, 8'hFF);
    check("static_uio", uio_out, 8'hA5);
    en_reg_out_7_0 = 8'h3C; en_reg_pwm_7_0 = 8'h0F;
    @(negedge clk);
    check("mixed_duty0_uo", uo_out, 8'h30);

    en_reg_out_7_0 = 8'h01; en_reg_pwm_7_0 = 8'h01;
    en_reg_out_15_8 = 8'h00; en_reg_pwm_15_8 = 8'hFF;
    pwm_duty_cycle = 8'h80;
    wait_strobe("sync80");
    for (int p = 0; p < 2; p++) begin
      measure(hi, len, rise, uor);
      check($sformatf("d80_hi_p%0d", p), hi, 1664);
      check($sformatf("d80_len_p%0d", p), len, 3315);
      check($sformatf("d80_rise_p%0d", p), rise, 1);
      check($sformatf("d80_uio_p%0d", p), uor, 0);
    end

    pwm_duty_cycle = 8'h00;
    wait_strobe("sync00a");
    wait_strobe("sync00b");
    for (int p = 0; p < 2; p++) begin
      measure(hi, len, rise, uor);
      check($sformatf("d00_hi_p%0d", p), hi, 0);
    end
    pwm_duty_cycle = 8'hFF;
    wait_strobe("syncffa");
    wait_strobe("syncffb");
    for (int p = 0; p < 2; p++) begin
      measure(hi, len, rise, uor);
      check($sformatf("dff_hi_p%0d", p), hi, 3315);
    end

    pwm_duty_cycle = 8'h40;
    wait_strobe("sync40a");
    wait_strobe("sync40b");
    hi = 0; len = 0; o100 = 1'b0; o101 = 1'b0;
    do begin
      if (len == 1300) begin o100 = uo_out[0]; pwm_duty_cycle = 8'hC0; end
      if (len == 1301) o101 = uo_out[0];
      hi += int'(uo_out[0]);
      len++;
      @(negedge clk);
    end while (!pwm_period_start && len < 4000);
    check("chg_out_at100", o100, 0);
`ifdef PWM_SHADOW_EN
    check("chg_out_next", o101, 0);
    check("chg_hi_cur", hi, 832);
    measure(hi, len, rise, uor);
    check("chg_hi_next", hi, 2496);
`else
    check("chg_out_next", o101, 1);
    check("chg_hi_cur", hi, 2028);
`endif

    en_reg_out_7_0 = 8'hFF; en_reg_pwm_7_0 = 8'h00;
    en_reg_out_15_8 = 8'hA5; en_reg_pwm_15_8 = 8'h00;
    wait_strobe("sync_rst");
    repeat (2600) @(negedge clk);
    check("pre_rst_uo", uo_out, 8'hFF);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_uo", uo_out, 0);
    check("mid_rst_uio", uio_out, 0);
    check("mid_rst_pps", pwm_period_start, 0);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check("post_rst_uo", uo_out, 8'hFF);
    end while (!pwm_period_start && n < 4000);
    check("post_rst_pps_delay", n, 3315);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_peripheral.md
PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
Parameters:
REQ-001 SHALL provide parameter CLK_DIV, default 13, clk cycles per PWM counter step; legal range 1..65535.
Ports:
REQ-002 SHALL provide clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL provide rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL provide en_reg_out_7_0  input  8  output-enable, channels 7..0.
REQ-005 SHALL provide en_reg_out_15_8  input  8  output-enable, channels 15..8.
REQ-006 SHALL provide en_reg_pwm_7_0  input  8  PWM-mode select, channels 7..0.
REQ-007 SHALL provide en_reg_pwm_15_8  input  8  PWM-mode select, channels 15..8.
REQ-008 SHALL provide pwm_duty_cycle  input  8  duty value shared by all PWM channels.
REQ-009 SHALL provide uo_out  output  8  channel outputs 7..0, registered.
REQ-010 SHALL provide uio_out  output  8  channel outputs 15..8, registered.
REQ-011 SHALL provide pwm_period_start  output  1  one-cycle strobe at each PWM period start, registered.

Function
REQ-012 SHALL implement a 16-bit prescaler counting 0..CLK_DIV-1 and wrapping to 0; tick asserted when prescaler == CLK_DIV-1; CLK_DIV=1 means tick every cycle.
REQ-013 SHALL implement an 8-bit pwm_cnt that advances only on tick, counting 0..254, then wrapping 254 -> 0; period = 255*CLK_DIV clk cycles (3315 at default).
REQ-014 SHALL compute pwm_hi = (pwm_cnt < duty_eff), unsigned 8-bit compare; duty 0x00 gives constant low, duty 0xFF gives constant high, no glitch at the wrap.
REQ-015 SHALL set each channel output register i, every cycle, to en_out[i] AND (NOT en_pwm[i] OR pwm_hi).
REQ-016 SHALL give one-cycle latency from any enable/duty/counter change to uo_out/uio_out.
REQ-017 SHALL hold a channel low whenever en_out[i]=0, regardless of en_pwm[i].
REQ-018 SHALL pulse pwm_period_start high for exactly one cycle: the cycle in which pwm_cnt first reads 0 after a wrap; no pulse on reset release.
REQ-019 SHALL leave the prescaler and pwm_cnt free-running, independent of the enable inputs.
REQ-020 SHALL apply enable register changes on the next clock, with no waiting for a period boundary.

Reset
REQ-021 SHALL, on clk edge with rst=1, clear prescaler, pwm_cnt, active duty register, uo_out, uio_out and pwm_period_start to 0.
REQ-022 SHALL, on rst asserted mid-period, abandon the period; first cycle after release has prescaler=0 and pwm_cnt=0, and the first pwm_period_start comes 255*CLK_DIV cycles later.
REQ-023 SHALL give rst priority over every other update in the same cycle.

Configuration
REQ-024 SHALL support macro PWM_SHADOW_EN. Defined: duty_eff is an 8-bit shadow register loaded from pwm_duty_cycle only on the cycle where tick=1 and pwm_cnt=254, so duty changes take effect at the next period start; shadow resets to 0.
REQ-025 SHALL, without PWM_SHADOW_EN, make duty_eff = pwm_duty_cycle directly, so a duty change affects the compare on the next cycle, mid-period.

Verification (CLK_DIV=13)
REQ-026 SHALL test: en_out_7_0=0xFF, en_pwm=0x00 -> uo_out=0xFF one cycle later; en_out_15_8=0xA5 -> uio_out=0xA5.
REQ-027 SHALL test: en_out_7_0=0x01, en_pwm_7_0=0x01, duty=0x80 -> uo_out[0] high 1664 of every 3315 cycles; rising edge aligned with pwm_period_start.
REQ-028 SHALL test: duty=0x00 -> uo_out[0] constant 0 over 2 periods; duty=0xFF -> constant 1 over 2 periods.
REQ-029 SHALL test: en_out_15_8=0x00, en_pwm_15_8=0xFF, duty=0x80 -> uio_out stays 0x00.
REQ-030 SHALL test: duty 0x40 -> 0xC0 at pwm_cnt=100; with PWM_SHADOW_EN the current period stays at 832 high cycles and the next period is 2496; without the macro the output goes high on the next cycle.
REQ-031 SHALL test: rst pulsed 1 cycle at pwm_cnt=200 -> all outputs 0 the next cycle, pwm_period_start exactly 3315 cycles after release.
